ss_scan_decoder: RTL

SS_SCAN_DECODER -- requirements
Module: ss_scan_decoder

---
 rtl/ss_pkg.sv | 30 +++
 rtl/ss_seg_to_hex.sv | 35 +++
 rtl/ss_scan_decoder.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/ss_pkg.sv
// Shared definitions for the seven-segment scan decoder: digit count, active-low
// hex glyph patterns (bit6 = a .. bit0 = g) and the capture FSM states.
package ss_pkg;

    localparam int unsigned NUM_DIGITS = 4;

    localparam logic [6:0] GLYPH_0 = 7'b0000001;
    localparam logic [6:0] GLYPH_1 = 7'b1001111;
    localparam logic [6:0] GLYPH_2 = 7'b0010010;
    localparam logic [6:0] GLYPH_3 = 7'b0000110;
    localparam logic [6:0] GLYPH_4 = 7'b1001100;
    localparam logic [6:0] GLYPH_5 = 7'b0100100;
    localparam logic [6:0] GLYPH_6 = 7'b0100000;
    localparam logic [6:0] GLYPH_7 = 7'b0001111;
    localparam logic [6:0] GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0000100;
    localparam logic [6:0] GLYPH_A = 7'b0001000;
    localparam logic [6:0] GLYPH_B = 7'b1100000;
    localparam logic [6:0] GLYPH_C = 7'b0110001;
    localparam logic [6:0] GLYPH_D = 7'b1000010;
    localparam logic [6:0] GLYPH_E = 7'b0110000;
    localparam logic [6:0] GLYPH_F = 7'b0111000;

    typedef enum logic [1:0] {
        StSettling,
        StAct,
        StDwell
    } ss_state_e;

endpackage

// File: rtl/ss_seg_to_hex.sv
// Combinational glyph lookup: active-low segment pattern to hex nibble.
// Unrecognised patterns (including all segments off) give nibble 0 with ok low.
module ss_seg_to_hex
    import ss_pkg::*;
(
    input  logic [6:0] seg_l,
    output logic [3:0] nibble,
    output logic       ok
);

    always_comb begin
        nibble = 4'h0;
        ok     = 1'b1;
        unique case (seg_l)
            GLYPH_0: nibble = 4'h0;
            GLYPH_1: nibble = 4'h1;
            GLYPH_2: nibble = 4'h2;
            GLYPH_3: nibble = 4'h3;
            GLYPH_4: nibble = 4'h4;
            GLYPH_5: nibble = 4'h5;
            GLYPH_6: nibble = 4'h6;
            GLYPH_7: nibble = 4'h7;
            GLYPH_8: nibble = 4'h8;
            GLYPH_9: nibble = 4'h9;
            GLYPH_A: nibble = 4'hA;
            GLYPH_B: nibble = 4'hB;
            GLYPH_C: nibble = 4'hC;
            GLYPH_D: nibble = 4'hD;
            GLYPH_E: nibble = 4'hE;
            GLYPH_F: nibble = 4'hF;
            default: ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/ss_scan_decoder.sv
// Recovers the value shown on a multiplexed 4-digit seven-segment display by
// sampling its drive lines, waiting for each select to settle and assembling frames.
module ss_scan_decoder
    import ss_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65536
) (
    input  logic                      clk,
    input  logic                      rst_l,
    input  logic [6:0]                ss_abcdefg_l,
    input  logic                      ss_dp_l,
    input  logic [NUM_DIGITS-1:0]     ss_sel_l,
    output logic [4*NUM_DIGITS-1:0]   digits,
    output logic [NUM_DIGITS-1:0]     dps,
    output logic [NUM_DIGITS-1:0]     digit_ok,
    output logic                      frame_valid,
    output logic                      sel_err,
    output logic                      stale
);

    localparam int unsigned SAMPLE_W = NUM_DIGITS + 8;
    localparam int unsigned CNT_W    = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned IDLE_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  SETTLE_MAX = CNT_W'(SETTLE_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_MAX   = IDLE_W'(TIMEOUT_CYCLES);

    logic [SAMPLE_W-1:0]     sample_q, prev_q;
    logic [CNT_W-1:0]        settle_cnt_q, settle_cnt_d;
    ss_state_e               state_q, state_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic [4*NUM_DIGITS-1:0] shadow_digits_q, shadow_digits_d;
    logic [NUM_DIGITS-1:0]   shadow_dps_q, shadow_dps_d;
    logic [NUM_DIGITS-1:0]   shadow_ok_q, shadow_ok_d;
    logic [4*NUM_DIGITS-1:0] digits_q;
    logic [NUM_DIGITS-1:0]   dps_q, digit_ok_q;
    logic                    frame_valid_q, sel_err_q, sel_err_d;
    logic [IDLE_W-1:0]       idle_q, idle_d;
    logic                    stale_q, stale_d;

    logic                  changed, act, one_hot, capture, frame_done;
    logic [NUM_DIGITS-1:0] sel_hot, seen_next;
    logic [6:0]            act_seg_l;
    logic [3:0]            glyph_nibble;
    logic                  glyph_ok;

    // During ACT the settled sample lives in prev_q; sample_q may already hold a new one.
    assign sel_hot   = ~prev_q[SAMPLE_W-1 -: NUM_DIGITS];
    assign act_seg_l = prev_q[7:1];
    assign changed   = (sample_q != prev_q);
    assign act       = (state_q == StAct);
    assign one_hot   = (sel_hot != '0) && ((sel_hot & (sel_hot - 1'b1)) == '0);
    assign capture   = act && one_hot;
    assign seen_next = seen_q | sel_hot;
    assign frame_done = capture && (seen_next == '1);

    ss_seg_to_hex u_seg_to_hex (
        .seg_l  (act_seg_l),
        .nibble (glyph_nibble),
        .ok     (glyph_ok)
    );

    always_comb begin
        settle_cnt_d = settle_cnt_q;
        state_d      = state_q;
        if (changed) begin
            settle_cnt_d = '0;
        end else if (settle_cnt_q != SETTLE_MAX) begin
            settle_cnt_d = settle_cnt_q + 1'b1;
        end

        if (changed) begin
            state_d = StSettling;
        end else begin
            case (state_q)
                StSettling: if (settle_cnt_d == SETTLE_MAX) state_d = StAct;
                StAct:      state_d = StDwell;
                StDwell:    state_d = StDwell;
                default:    state_d = StSettling;
            endcase
        end
    end

    always_comb begin
        shadow_digits_d = shadow_digits_q;
        shadow_dps_d    = shadow_dps_q;
        shadow_ok_d     = shadow_ok_q;
        seen_d          = seen_q;
        sel_err_d       = act && !one_hot && (sel_hot != '0);
        if (capture) begin
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                if (sel_hot[i]) begin
                    shadow_digits_d[4*i +: 4] = glyph_nibble;
                    shadow_dps_d[i]           = ~prev_q[0];
                    shadow_ok_d[i]            = glyph_ok;
                end
            end
            seen_d = frame_done ? '0 : seen_next;
        end

        if (capture) begin
            idle_d = '0;
        end else if (idle_q != IDLE_MAX) begin
            idle_d = idle_q + 1'b1;
        end else begin
            idle_d = idle_q;
        end
        stale_d = frame_done ? 1'b0 : (stale_q | (idle_d == IDLE_MAX));
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            sample_q        <= '0;
            prev_q          <= '0;
            settle_cnt_q    <= '0;
            state_q         <= StSettling;
            seen_q          <= '0;
            shadow_digits_q <= '0;
            shadow_dps_q    <= '0;
            shadow_ok_q     <= '0;
            digits_q        <= '0;
            dps_q           <= '0;
            digit_ok_q      <= '0;
            frame_valid_q   <= 1'b0;
            sel_err_q       <= 1'b0;
            idle_q          <= '0;
            stale_q         <= 1'b0;
        end else begin
            sample_q        <= {ss_sel_l, ss_abcdefg_l, ss_dp_l};
            prev_q          <= sample_q;
            settle_cnt_q    <= settle_cnt_d;
            state_q         <= state_d;
            seen_q          <= seen_d;
            shadow_digits_q <= shadow_digits_d;
            shadow_dps_q    <= shadow_dps_d;
            shadow_ok_q     <= shadow_ok_d;
            frame_valid_q   <= frame_done;
            sel_err_q       <= sel_err_d;
            idle_q          <= idle_d;
            stale_q         <= stale_d;
            // Publish the shadow including the digit captured this very cycle.
            if (frame_done) begin
                digits_q   <= shadow_digits_d;
                dps_q      <= shadow_dps_d;
                digit_ok_q <= shadow_ok_d;
            end
        end
    end

    assign digits      = digits_q;
    assign dps         = dps_q;
    assign digit_ok    = digit_ok_q;
    assign frame_valid = frame_valid_q;
    assign sel_err     = sel_err_q;
    assign stale       = stale_q;

endmodule
